seg_display_ctrl: RTL and testbench
===================================

# seg_display_ctrl

Sequential display back end for the logic unit: captures an 8-bit result, its op code and parity flags on a load handshake, then time-multiplexes them onto a 4-digit common-anode seven-segment display. It sits between the logic unit outputs and the board display pins. A post-load hold interval guarantees that every accepted value is shown for at least one full scan frame.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays lit; legal range ≥ 2.
- BLINK_LOG2, 24: blink half-period is 2^BLINK_LOG2 cycles; used only with SEG_BLINK_EN.
- clk_pi  in  1  system clock; all state changes on the rising edge.
- rst_n_pi  in  1  reset, asynchronous, active-low.
- load_pi  in  1  capture request; accepted only when ready_po=1.
- result_pi  in  8  value to display.
- op_pi  in  4  operation code to display.
- p_en_pi  in  1  parity indicator enable.
- p_value_pi  in  1  parity flag: 1 = even, 0 = odd.
- ready_po  out  1  high when a load will be accepted.
- an_po  out  4  digit anodes, active-low, one-hot-low.
- seg_po  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_po  out  1  decimal point, active-low.

## Operation
- Captured registers: res_q[7:0], op_q[3:0], pen_q, pval_q.
- Digit map: digit0 shows res_q[3:0] in hex, digit1 shows res_q[7:4] in hex, digit2 shows op_q in hex, digit3 shows 'E' (0x06) if pen_q&pval_q, 'o' (0x23) if pen_q&~pval_q, and blank (0x7F) if ~pen_q.
- dp_po is low only while digit2 is lit and pen_q=1.
- FSM states:
  - IDLE (after reset): an_po=1111, no scanning, ready_po=1.
  - HOLD: scanning, ready_po=0.
  - SHOW: scanning, ready_po=1.
- Transitions:
  - Accepted load in any state → HOLD. Captures inputs, clears refresh counter, digit index and frame counter.
  - HOLD → SHOW after 4·REFRESH_DIV cycles.
  - SHOW persists until the next load.
- A load with ready_po=0 is ignored: not queued, no register change.
- Scan: refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps and the digit index advances 0→1→2→3→0.

## Timing
- Reset values (asynchronous, immediate): an_po=1111, seg_po=7'h7F, dp_po=1, ready_po=1, state IDLE, all counters and captured registers 0.
- Load sampled at edge E0: captured registers and state update at E0, ready_po is low from E0.
- At edge E1, registered outputs show digit0 with an_po=1110. Display latency is 1 cycle after capture.
- Each digit is lit for exactly REFRESH_DIV cycles. The digit index wraps 3→0 seamlessly with no blank gap.
- ready_po returns high exactly 4·REFRESH_DIV cycles after E0.
- Load in the same cycle that HOLD ends: ready_po is still 0, so the load is ignored.
- Load during SHOW restarts the scan at digit0.
- Reset asserted mid-HOLD or mid-scan: all outputs go to reset values at once. After release the block waits in IDLE.

## Configuration
- SEG_BLINK_EN defined:
  - When pen_q=1 and pval_q=0, digit3 alternates between 'o' and blank every 2^BLINK_LOG2 cycles.
  - The blink counter is free-running from reset.
  - Other digits are unaffected.
- SEG_BLINK_EN undefined: no blink counter; digit3 shows 'o' steadily; BLINK_LOG2 is ignored.

## Structure
- seg_display_pkg:
  - state enum (IDLE, HOLD, SHOW).
  - segment constants SEG_BLANK, SEG_E, SEG_O.
  - 16-entry hex-to-segment table.
- Sub-module hex_to_seg7: combinational 4-bit → 7-bit active-low decoder, instantiated once on the muxed nibble.
- Counter width: $clog2(REFRESH_DIV) for the refresh counter; frame counter of 2 bits plus the refresh counter.

## Test plan
Benches run with REFRESH_DIV=4, BLINK_LOG2=3.
- Reset held 10 cycles, then released without a load → an_po=1111, seg_po=7F, dp_po=1, ready_po=1, all stable.
- Load result=A5, op=1, p_en=1, p_value=1 → an_po 1110/1101/1011/0111, 4 cycles each, with seg 12/08/79/06; dp_po low only on digit2; ready_po low for 16 cycles.
- During HOLD of the previous case, load result=3C → ignored; digits still 5, A after wrap; ready_po rises at cycle 16.
- In SHOW, load result=FF, op=8, p_en=0 → digit0 and digit1 show 0x0E, digit3 shows 7F, dp_po stays high, scan restarts at an_po=1110.
- Assert rst_n_pi mid-HOLD → same-cycle an_po=1111, seg_po=7F, ready_po=1; after release stays IDLE.
- With SEG_BLINK_EN defined, load p_en=1, p_value=0 → digit3 toggles between 23 and 7F every 8 cycles. Without the macro, digit3 is a constant 23.

Source files
------------

// File: rtl/seg_display_pkg.sv
// ----------------------------------------------------------------------------
// seg_display_pkg
//   Shared types and constants for the seven-segment display back end.
//   - state_e        : controller states (IDLE, HOLD, SHOW)
//   - SEG_BLANK/E/O  : active-low segment patterns {g,f,e,d,c,b,a}
//   - HEX_SEG_TABLE  : 16-entry hex digit to active-low segment table
//   - digit_anode()  : one-hot-low anode pattern for a digit index
// ----------------------------------------------------------------------------
package seg_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SHOW = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_O     = 7'h23;

    localparam logic [3:0] AN_OFF    = 4'hF;

    // Entry i holds the pattern for hex digit i (entry 15 is listed first).
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [3:0] digit_anode(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_display_hex_to_seg7.sv
// ----------------------------------------------------------------------------
// hex_to_seg7
//   Combinational 4-bit hex to 7-segment decoder, active-low outputs.
//   Ports:
//     nibble_i  in  4  hex value
//     seg_o     out 7  segments {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module hex_to_seg7
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_display_ctrl.sv
// ----------------------------------------------------------------------------
// seg_display_ctrl
//   Captures an 8-bit result, its op code and parity flags on a load
//   handshake and time-multiplexes them onto a 4-digit common-anode
//   seven-segment display. After each accepted load the block refuses new
//   loads for one full scan frame (4 * REFRESH_DIV cycles) so every value is
//   shown at least once.
//
//   Digit map: 0 = result[3:0], 1 = result[7:4], 2 = op, 3 = parity symbol
//   ('E' even, 'o' odd, blank when parity is disabled). The decimal point is
//   lit on digit 2 whenever parity is enabled.
//
//   Optional feature: define SEG_BLINK_EN to blink the odd-parity 'o' on
//   digit 3 with a half-period of 2^BLINK_LOG2 cycles.
//
//   Parameters:
//     REFRESH_DIV  cycles each digit stays lit (>= 2)
//     BLINK_LOG2   log2 of the blink half-period (SEG_BLINK_EN only)
//   Ports:
//     clk_pi      in  1  system clock
//     rst_n_pi    in  1  asynchronous active-low reset
//     load_pi     in  1  capture request, accepted when ready_po=1
//     result_pi   in  8  value to display
//     op_pi       in  4  operation code to display
//     p_en_pi     in  1  parity indicator enable
//     p_value_pi  in  1  parity flag, 1 = even
//     ready_po    out 1  load will be accepted
//     an_po       out 4  digit anodes, active-low one-hot
//     seg_po      out 7  segments {g,f,e,d,c,b,a}, active-low
//     dp_po       out 1  decimal point, active-low
// ----------------------------------------------------------------------------
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_LOG2  = 24
) (
    input  logic       clk_pi,
    input  logic       rst_n_pi,
    input  logic       load_pi,
    input  logic [7:0] result_pi,
    input  logic [3:0] op_pi,
    input  logic       p_en_pi,
    input  logic       p_value_pi,
    output logic       ready_po,
    output logic [3:0] an_po,
    output logic [6:0] seg_po,
    output logic       dp_po
);

    localparam int              CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   REF_LAST = CW'(REFRESH_DIV - 1);

    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("REFRESH_DIV must be at least 2");
    end
    if (BLINK_LOG2 < 1) begin : g_bad_blink
        $error("BLINK_LOG2 must be at least 1");
    end

    state_e        state_q;
    logic          ready_q;
    logic [7:0]    res_q;
    logic [3:0]    op_q;
    logic          pen_q;
    logic          pval_q;
    logic [CW-1:0] ref_q;
    logic [1:0]    dig_q;
    logic [1:0]    frame_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;
    logic [3:0]    nibble;
    logic [6:0]    hex_seg;
    logic [6:0]    parity_seg;
    logic          accept;
    logic          ref_wrap;

    assign accept   = load_pi & ready_q;
    assign ref_wrap = (ref_q == REF_LAST);

`ifdef SEG_BLINK_EN
    localparam int BW = BLINK_LOG2 + 1;

    // Free-running from reset; the MSB toggles every 2^BLINK_LOG2 cycles.
    logic [BW-1:0] blink_q;

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + BW'(1);
        end
    end
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned and infers a latch.
        nibble = 4'h0;
        case (dig_q)
            2'd0:    nibble = res_q[3:0];
            2'd1:    nibble = res_q[7:4];
            2'd2:    nibble = op_q;
            default: nibble = 4'h0;
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nibble),
        .seg_o    (hex_seg)
    );

    always_comb begin
        parity_seg = SEG_BLANK;
        if (pen_q) begin
            parity_seg = pval_q ? SEG_E : SEG_O;
        end
`ifdef SEG_BLINK_EN
        if (pen_q && !pval_q && blink_q[BW-1]) begin
            parity_seg = SEG_BLANK;
        end
`endif
    end

    // Next value of the registered display outputs, taken from the current
    // digit index so the display trails the scan state by one cycle.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_q != ST_IDLE) begin
            an_d  = digit_anode(dig_q);
            seg_d = (dig_q == 2'd3) ? parity_seg : hex_seg;
            dp_d  = ~((dig_q == 2'd2) & pen_q);
        end
    end

    // NOTE: captured operands are ordinary flops (not a memory), so they are
    // cleared by reset together with the rest of the state.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            res_q   <= '0;
            op_q    <= '0;
            pen_q   <= 1'b0;
            pval_q  <= 1'b0;
            ref_q   <= '0;
            dig_q   <= '0;
            frame_q <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples values from before this edge.
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;

            if (accept) begin
                state_q <= ST_HOLD;
                ready_q <= 1'b0;
                res_q   <= result_pi;
                op_q    <= op_pi;
                pen_q   <= p_en_pi;
                pval_q  <= p_value_pi;
                ref_q   <= '0;
                dig_q   <= '0;
                frame_q <= '0;
            end else begin
                case (state_q)
                    ST_HOLD, ST_SHOW: begin
                        if (ref_wrap) begin
                            ref_q <= '0;
                            dig_q <= dig_q + 2'd1;
                        end else begin
                            ref_q <= ref_q + CW'(1);
                        end
                        // One full frame (four digit slots) ends the hold.
                        if (state_q == ST_HOLD && ref_wrap) begin
                            frame_q <= frame_q + 2'd1;
                            if (frame_q == 2'd3) begin
                                state_q <= ST_SHOW;
                                ready_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ready_po = ready_q;
    assign an_po    = an_q;
    assign seg_po   = seg_q;
    assign dp_po    = dp_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg_display_ctrl
//   Self-checking bench for seg_display_ctrl with REFRESH_DIV=4, BLINK_LOG2=3.
//   A behavioural model tracks "cycles since the last accepted load" and
//   derives the lit digit, segments and ready from that count; a compare
//   process checks the DUT against it on every falling edge. Directed
//   sequences add literal expectations; a random phase follows.
// ----------------------------------------------------------------------------
module tb_seg_display_ctrl;

    localparam int RD = 4;
    localparam int BL = 3;

    logic       clk_pi     = 1'b0;
    logic       rst_n_pi   = 1'b1;
    logic       load_pi    = 1'b0;
    logic [7:0] result_pi  = '0;
    logic [3:0] op_pi      = '0;
    logic       p_en_pi    = 1'b0;
    logic       p_value_pi = 1'b0;
    logic       ready_po;
    logic [3:0] an_po;
    logic [6:0] seg_po;
    logic       dp_po;

    seg_display_ctrl #(
        .REFRESH_DIV (RD),
        .BLINK_LOG2  (BL)
    ) dut (
        .clk_pi     (clk_pi),
        .rst_n_pi   (rst_n_pi),
        .load_pi    (load_pi),
        .result_pi  (result_pi),
        .op_pi      (op_pi),
        .p_en_pi    (p_en_pi),
        .p_value_pi (p_value_pi),
        .ready_po   (ready_po),
        .an_po      (an_po),
        .seg_po     (seg_po),
        .dp_po      (dp_po)
    );

    always #5 clk_pi = ~clk_pi;

    int n_checks = 0;
    int n_passed = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_passed++;
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24;
            4'h3: return 7'h30; 4'h4: return 7'h19; 4'h5: return 7'h12;
            4'h6: return 7'h02; 4'h7: return 7'h78; 4'h8: return 7'h00;
            4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    bit          m_loaded = 1'b0;
    int unsigned m_t      = 0;    // cycles since the last accepted load
    int unsigned m_n      = 0;    // cycles since reset release
    logic [7:0]  m_res    = '0;
    logic [3:0]  m_op     = '0;
    bit          m_pen    = 1'b0;
    bit          m_pval   = 1'b0;
    logic [3:0]  exp_an    = 4'hF;
    logic [6:0]  exp_seg   = 7'h7F;
    logic        exp_dp    = 1'b1;
    logic        exp_ready = 1'b1;
    int          m_d;
    bit          m_blank3;

    function automatic bit model_ready();
        return !m_loaded || (m_t >= 4 * RD);
    endfunction

    always @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            m_loaded = 1'b0; m_t = 0; m_n = 0;
            m_res = '0; m_op = '0; m_pen = 1'b0; m_pval = 1'b0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ready = 1'b1;
        end else begin
            // Display registers show the model state from before this edge.
            if (!m_loaded) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                m_d    = (m_t / RD) % 4;
                exp_an = 4'hF ^ (4'h1 << m_d);
                exp_dp = !(m_d == 2 && m_pen);
`ifdef SEG_BLINK_EN
                m_blank3 = ((m_n >> BL) & 1) != 0;
`else
                m_blank3 = 1'b0;
`endif
                case (m_d)
                    0: exp_seg = hex7(m_res[3:0]);
                    1: exp_seg = hex7(m_res[7:4]);
                    2: exp_seg = hex7(m_op);
                    default: exp_seg = !m_pen ? 7'h7F :
                                       m_pval ? 7'h06 :
                                       m_blank3 ? 7'h7F : 7'h23;
                endcase
            end
            if (load_pi && model_ready()) begin
                m_loaded = 1'b1; m_t = 0;
                m_res = result_pi; m_op = op_pi;
                m_pen = p_en_pi; m_pval = p_value_pi;
            end else if (m_loaded && m_t < 32'h1000_0000) begin
                m_t++;
            end
            m_n++;
            exp_ready = model_ready();
        end
    end

    always @(negedge clk_pi) begin
        if (cmp_en) begin
            check("model_an",    an_po,    exp_an);
            check("model_seg",   seg_po,   exp_seg);
            check("model_dp",    dp_po,    exp_dp);
            check("model_ready", ready_po, exp_ready);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive_load(input logic [7:0] r, input logic [3:0] o,
                              input logic pe, input logic pv);
        load_pi = 1'b1; result_pi = r; op_pi = o; p_en_pi = pe; p_value_pi = pv;
    endtask

    logic [3:0] an_lit  [4];
    logic [6:0] a5_seg  [4];
    logic [6:0] ff_seg  [4];

    initial begin
        int d;
        an_lit = '{4'hE, 4'hD, 4'hB, 4'h7};
        a5_seg = '{7'h12, 7'h08, 7'h79, 7'h06};
        ff_seg = '{7'h0E, 7'h0E, 7'h00, 7'h7F};

        rst_n_pi = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (10) @(negedge clk_pi);
        rst_n_pi = 1'b1;
        repeat (5) @(negedge clk_pi);
        check("idle_an",    an_po,    4'hF);
        check("idle_seg",   seg_po,   7'h7F);
        check("idle_dp",    dp_po,    1'b1);
        check("idle_ready", ready_po, 1'b1);

        // Load A5 / op 1 / even parity; ignored loads at cycle 5 and 15.
        drive_load(8'hA5, 4'h1, 1'b1, 1'b1);
        @(negedge clk_pi);
        load_pi = 1'b0;
        check("a5_ready_low", ready_po, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_pi);
            d = ((k - 1) / 4) % 4;
            check("a5_an",    an_po,    an_lit[d]);
            check("a5_seg",   seg_po,   a5_seg[d]);
            check("a5_dp",    dp_po,    (d == 2) ? 1'b0 : 1'b1);
            check("a5_ready", ready_po, (k >= 16) ? 1'b1 : 1'b0);
            if (k == 5 || k == 15) drive_load(8'h3C, 4'h2, 1'b0, 1'b0);
            if (k == 6 || k == 16) load_pi = 1'b0;
        end

        // Load in SHOW restarts the scan.
        drive_load(8'hFF, 4'h8, 1'b0, 1'b0);
        @(negedge clk_pi);
        load_pi = 1'b0;
        check("ff_ready_low", ready_po, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_pi);
            d = ((k - 1) / 4) % 4;
            check("ff_an",  an_po,  an_lit[d]);
            check("ff_seg", seg_po, ff_seg[d]);
            check("ff_dp",  dp_po,  1'b1);
        end

        // Reset asserted mid-HOLD.
        drive_load(8'hA5, 4'h1, 1'b1, 1'b1);
        @(negedge clk_pi);
        load_pi = 1'b0;
        repeat (5) @(negedge clk_pi);
        #2 rst_n_pi = 1'b0;
        #1;
        check("rst_an",    an_po,    4'hF);
        check("rst_seg",   seg_po,   7'h7F);
        check("rst_dp",    dp_po,    1'b1);
        check("rst_ready", ready_po, 1'b1);
        repeat (3) @(negedge clk_pi);
        rst_n_pi = 1'b1;
        repeat (10) @(negedge clk_pi);
        check("post_rst_an",    an_po,    4'hF);
        check("post_rst_seg",   seg_po,   7'h7F);
        check("post_rst_ready", ready_po, 1'b1);

        // Odd parity on digit 3 (steady or blinking depending on build).
        drive_load(8'h77, 4'h3, 1'b1, 1'b0);
        @(negedge clk_pi);
        load_pi = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_pi);
`ifndef SEG_BLINK_EN
            if (k >= 13 && k <= 16) check("odd_steady_seg", seg_po, 7'h23);
`endif
        end

        // Randomized phase, checked by the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_pi);
            load_pi    = ($urandom_range(0, 5) == 0);
            result_pi  = 8'($urandom);
            op_pi      = 4'($urandom);
            p_en_pi    = 1'($urandom);
            p_value_pi = 1'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #3 rst_n_pi = 1'b0;
                @(negedge clk_pi);
                rst_n_pi = 1'b1;
            end
        end
        load_pi = 1'b0;
        repeat (4) @(negedge clk_pi);
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
